// File: rtl/seven_seg_capture.sv
// Rebuilds the four digits shown on a scanned 4-digit seven-segment bus.
// Optional hex letters A-F are decoded when HEX_DECODE_EN is defined.
module seven_seg_capture #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [3:0]  i_display,
    input  logic [6:0]  i_segments,
    input  logic        i_clear,
    output logic [15:0] o_digits,
    output logic [27:0] o_seg_raw,
    output logic [3:0]  o_digit_valid,
    output logic        o_frame_done,
    output logic        o_anode_error
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX     = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [6:0]       SEG_OFF     = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [10:0]      SYNC_IDLE   = {4'hF, SEG_OFF};

    logic [10:0]      r_sync1;
    logic [10:0]      r_sync2;
    logic [10:0]      r_prev;
    logic [CNT_W-1:0] r_stable_cnt;
    logic [3:0]       r_seen;
    logic             r_frame_done;
    logic             r_anode_error;

    logic [3:0]       r_digit [4];
    logic [6:0]       r_raw   [4];
    logic             r_valid [4];
    logic [TMR_W-1:0] r_timer [4];

    logic [3:0]       w_anodes;
    logic [6:0]       w_pattern;
    logic [6:0]       w_lit;
    logic             w_same;
    logic             w_commit;
    logic [3:0]       w_sel;
    logic             w_single;
    logic             w_multi;
    logic [3:0]       w_dec_val;
    logic             w_dec_ok;

    assign w_anodes  = r_sync2[10:7];
    assign w_pattern = r_sync2[6:0];
    assign w_lit     = (SEG_ACTIVE_LOW != 0) ? ~w_pattern : w_pattern;
    assign w_same    = (r_sync2 == r_prev);
    assign w_commit  = w_same && (r_stable_cnt == STABLE_LAST);
    assign w_multi   = !w_single && (w_anodes != 4'hF);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= SYNC_IDLE;
            r_sync2 <= SYNC_IDLE;
            r_prev  <= SYNC_IDLE;
        end else begin
            r_sync1 <= {i_display, i_segments};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Counter saturates past the commit point so a held pattern commits only once.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_stable_cnt <= '0;
        end else if (i_clear || !w_same) begin
            r_stable_cnt <= '0;
        end else if (r_stable_cnt != STABLE_MAX) begin
            r_stable_cnt <= r_stable_cnt + 1'b1;
        end
    end

    always_comb begin
        w_sel    = 4'b0000;
        w_single = 1'b0;
        case (w_anodes)
            4'b1110: begin w_sel = 4'b0001; w_single = 1'b1; end
            4'b1101: begin w_sel = 4'b0010; w_single = 1'b1; end
            4'b1011: begin w_sel = 4'b0100; w_single = 1'b1; end
            4'b0111: begin w_sel = 4'b1000; w_single = 1'b1; end
            default: ;
        endcase
    end

    // Lit-segment set, bit0=a .. bit6=g.
    always_comb begin
        w_dec_val = 4'hF;
        w_dec_ok  = 1'b0;
        case (w_lit)
            7'h3F: begin w_dec_val = 4'd0; w_dec_ok = 1'b1; end
            7'h06: begin w_dec_val = 4'd1; w_dec_ok = 1'b1; end
            7'h5B: begin w_dec_val = 4'd2; w_dec_ok = 1'b1; end
            7'h4F: begin w_dec_val = 4'd3; w_dec_ok = 1'b1; end
            7'h66: begin w_dec_val = 4'd4; w_dec_ok = 1'b1; end
            7'h6D: begin w_dec_val = 4'd5; w_dec_ok = 1'b1; end
            7'h7D: begin w_dec_val = 4'd6; w_dec_ok = 1'b1; end
            7'h07: begin w_dec_val = 4'd7; w_dec_ok = 1'b1; end
            7'h7F: begin w_dec_val = 4'd8; w_dec_ok = 1'b1; end
            7'h6F: begin w_dec_val = 4'd9; w_dec_ok = 1'b1; end
`ifdef HEX_DECODE_EN
            7'h77: begin w_dec_val = 4'hA; w_dec_ok = 1'b1; end
            7'h7C: begin w_dec_val = 4'hB; w_dec_ok = 1'b1; end
            7'h39: begin w_dec_val = 4'hC; w_dec_ok = 1'b1; end
            7'h5E: begin w_dec_val = 4'hD; w_dec_ok = 1'b1; end
            7'h79: begin w_dec_val = 4'hE; w_dec_ok = 1'b1; end
            7'h71: begin w_dec_val = 4'hF; w_dec_ok = 1'b1; end
`endif
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            always_ff @(posedge i_clock or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    r_digit[gi] <= 4'h0;
                    r_raw[gi]   <= SEG_OFF;
                    r_valid[gi] <= 1'b0;
                    r_timer[gi] <= '0;
                end else if (i_clear) begin
                    r_digit[gi] <= 4'h0;
                    r_raw[gi]   <= SEG_OFF;
                    r_valid[gi] <= 1'b0;
                    r_timer[gi] <= '0;
                end else if (w_commit && w_single && w_sel[gi]) begin
                    r_digit[gi] <= w_dec_val;
                    r_raw[gi]   <= w_pattern;
                    r_valid[gi] <= w_dec_ok;
                    r_timer[gi] <= '0;
                end else begin
                    if (r_timer[gi] != TMR_MAX)
                        r_timer[gi] <= r_timer[gi] + 1'b1;
                    if (r_timer[gi] == TMR_LAST)
                        r_valid[gi] <= 1'b0;
                end
            end

            assign o_digits[4*gi +: 4]  = r_digit[gi];
            assign o_seg_raw[7*gi +: 7] = r_raw[gi];
            assign o_digit_valid[gi]    = r_valid[gi];
        end
    endgenerate

    // A full seen mask is consumed one cycle after the commit that completed it.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_seen        <= 4'b0000;
            r_frame_done  <= 1'b0;
            r_anode_error <= 1'b0;
        end else if (i_clear) begin
            r_seen        <= 4'b0000;
            r_frame_done  <= 1'b0;
            r_anode_error <= 1'b0;
        end else begin
            r_frame_done  <= (r_seen == 4'hF);
            r_anode_error <= w_commit && w_multi;
            if (r_seen == 4'hF)
                r_seen <= (w_commit && w_single) ? w_sel : 4'b0000;
            else if (w_commit && w_single)
                r_seen <= r_seen | w_sel;
        end
    end

    assign o_frame_done  = r_frame_done;
    assign o_anode_error = r_anode_error;

endmodule
